// File: rtl/vic_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM encoding,
// vector width and the priority encoder that the level-select logic reuses.
package vic_pkg;

  localparam int VEC_W   = 9;
  localparam int MAX_SRC = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } vic_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } prio_t;

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  function automatic prio_t prio_enc(input logic [MAX_SRC-1:0] req);
    prio_t r;
    r.found = 1'b0;
    r.idx   = {IDX_W{1'b0}};
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vic_prio.sv
// Vectored interrupt controller for one bus priority level. Registers device
// requests, raises the level request, answers the CPU vector-fetch strobe with
// the highest-priority vector and pulses a grant once the strobe is removed.
module vic_prio
  import vic_pkg::*;
#(
  parameter int                NSRC     = 8,
  parameter logic [VEC_W-1:0]  SPUR_VEC = 9'o000
) (
  input  logic                   clk_p,
  input  logic                   rst,
  input  logic [NSRC-1:0]        ireq,
  input  logic [NSRC*VEC_W-1:0]  ivec_in,
  output logic [NSRC-1:0]        igrant,
  output logic                   irq_o,
  input  logic                   istb_i,
  output logic [VEC_W-1:0]       ivec_o,
  output logic                   iack_o
);

  vic_state_e       state_q, state_d;
  logic [NSRC-1:0]  req_q, req_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             hit_q, hit_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [NSRC-1:0]  igrant_q, igrant_d;
  logic             irq_q, irq_d;
  logic             iack_q, iack_d;
  logic [VEC_W-1:0] ivec_q, ivec_d;

  logic [MAX_SRC-1:0] req_pad;
  prio_t              enc;
  logic [VEC_W-1:0]   sel_vec;
  logic [NSRC-1:0]    sel_onehot;

  // Priority resolution of the registered requests and vector lookup.
  always_comb begin
    req_pad           = {MAX_SRC{1'b0}};
    req_pad[NSRC-1:0] = req_q;
    enc               = prio_enc(req_pad);
    sel_vec           = SPUR_VEC;
    for (int i = 0; i < NSRC; i++) begin
      sel_vec = (enc.found && (enc.idx == IDX_W'(i))) ? ivec_in[i*VEC_W +: VEC_W] : sel_vec;
    end
    for (int i = 0; i < NSRC; i++) begin
      sel_onehot[i] = (sel_q == IDX_W'(i));
    end
  end

  // Handshake FSM next state plus next values of every registered output.
  always_comb begin
    state_d  = state_q;
    req_d    = ireq;
    sel_d    = sel_q;
    hit_d    = hit_q;
    vec_d    = vec_q;
    igrant_d = {NSRC{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (istb_i) begin
          state_d = S_RESOLVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESOLVE: begin
        hit_d = enc.found;
        sel_d = enc.idx;
        vec_d = sel_vec;
        // A strobe already gone here is an aborted fetch: no ack, no grant.
        if (istb_i) begin
          state_d = S_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        // Grant on strobe removal so the CPU holds the vector before the
        // device is told to drop its request.
        if (!istb_i) begin
          state_d  = S_RELEASE;
          igrant_d = hit_q ? sel_onehot : {NSRC{1'b0}};
        end else begin
          state_d = S_ACK;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // The level request is masked during a fetch so it is not re-sampled.
    irq_d  = (|req_d) && !((state_d == S_RESOLVE) || (state_d == S_ACK));
    iack_d = (state_d == S_ACK);
    ivec_d = iack_d ? vec_d : {VEC_W{1'b0}};
  end

  // State and output registers, cleared asynchronously by bus reset.
  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= {NSRC{1'b0}};
      sel_q    <= {IDX_W{1'b0}};
      hit_q    <= 1'b0;
      vec_q    <= {VEC_W{1'b0}};
      igrant_q <= {NSRC{1'b0}};
      irq_q    <= 1'b0;
      iack_q   <= 1'b0;
      ivec_q   <= {VEC_W{1'b0}};
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      hit_q    <= hit_d;
      vec_q    <= vec_d;
      igrant_q <= igrant_d;
      irq_q    <= irq_d;
      iack_q   <= iack_d;
      ivec_q   <= ivec_d;
    end
  end

  assign igrant = igrant_q;
  assign irq_o  = irq_q;
  assign iack_o = iack_q;
  assign ivec_o = ivec_q;

endmodule

// File: tb/tb_vic_prio.sv
// Directed self-checking bench for vic_prio: basic grant, priority, spurious
// fetch, aborted fetch, request drop mid-fetch and reset mid-handshake.
module tb_vic_prio;

  localparam int NSRC = 8;

  logic             clk_p = 1'b0;
  logic             rst;
  logic [NSRC-1:0]  ireq;
  logic [NSRC*9-1:0] ivec_in;
  logic [NSRC-1:0]  igrant;
  logic             irq_o;
  logic             istb_i;
  logic [8:0]       ivec_o;
  logic             iack_o;

  int checks = 0;
  int errors = 0;

  vic_prio #(.NSRC(NSRC), .SPUR_VEC(9'o777)) dut (
    .clk_p   (clk_p),
    .rst     (rst),
    .ireq    (ireq),
    .ivec_in (ivec_in),
    .igrant  (igrant),
    .irq_o   (irq_o),
    .istb_i  (istb_i),
    .ivec_o  (ivec_o),
    .iack_o  (iack_o)
  );

  always #5 clk_p = ~clk_p;

  task automatic step();
    @(negedge clk_p);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full fetch: strobe held two ACK cycles, then released.
  task automatic fetch(input string tag, input logic [8:0] ev, input logic [NSRC-1:0] eg);
    istb_i = 1'b1;
    step();
    chk({tag, "_resolve_iack"}, 32'(iack_o), 32'd0);
    chk({tag, "_resolve_irq"}, 32'(irq_o), 32'd0);
    step();
    chk({tag, "_ack_iack"}, 32'(iack_o), 32'd1);
    chk({tag, "_ack_vec"}, 32'(ivec_o), 32'(ev));
    chk({tag, "_ack_nogrant"}, 32'(igrant), 32'd0);
    step();
    chk({tag, "_hold_vec"}, 32'(ivec_o), 32'(ev));
    istb_i = 1'b0;
    step();
    chk({tag, "_grant"}, 32'(igrant), 32'(eg));
    chk({tag, "_drop_iack"}, 32'(iack_o), 32'd0);
    chk({tag, "_drop_vec"}, 32'(ivec_o), 32'd0);
    step();
    chk({tag, "_grant_once"}, 32'(igrant), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    ireq    = 8'h00;
    istb_i  = 1'b0;
    ivec_in = {9'o114, 9'o110, 9'o070, 9'o104, 9'o060, 9'o050, 9'o064, 9'o100};
    step();
    step();
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_iack", 32'(iack_o), 32'd0);
    chk("rst_vec", 32'(ivec_o), 32'd0);
    chk("rst_grant", 32'(igrant), 32'd0);
    rst = 1'b0;
    step();

    // 1. basic grant
    ireq = 8'h08;
    chk("t1_irq_not_yet", 32'(irq_o), 32'd0);
    step();
    chk("t1_irq_rise", 32'(irq_o), 32'd1);
    step();
    step();
    fetch("t1", 9'o060, 8'h08);
    ireq = 8'h00;
    step();
    chk("t1_irq_clear", 32'(irq_o), 32'd0);

    // 2. priority
    ireq = 8'h22;
    step();
    step();
    fetch("t2a", 9'o064, 8'h02);
    ireq = 8'h20;
    step();
    chk("t2_irq_still", 32'(irq_o), 32'd1);
    fetch("t2b", 9'o070, 8'h20);
    ireq = 8'h00;
    step();
    step();

    // 3. spurious fetch
    fetch("t3", 9'o777, 8'h00);

    // 4. aborted fetch
    ireq = 8'h01;
    step();
    step();
    istb_i = 1'b1;
    step();
    istb_i = 1'b0;
    step();
    chk("t4_iack", 32'(iack_o), 32'd0);
    chk("t4_grant", 32'(igrant), 32'd0);
    chk("t4_idle_irq", 32'(irq_o), 32'd1);
    step();
    chk("t4_iack2", 32'(iack_o), 32'd0);
    chk("t4_grant2", 32'(igrant), 32'd0);
    fetch("t4", 9'o100, 8'h01);
    ireq = 8'h00;
    step();

    // 5. request drop mid-fetch
    ireq = 8'h04;
    step();
    step();
    istb_i = 1'b1;
    step();
    step();
    chk("t5_ack_vec", 32'(ivec_o), 32'(9'o050));
    ireq = 8'h00;
    step();
    chk("t5_vec_held", 32'(ivec_o), 32'(9'o050));
    chk("t5_iack_held", 32'(iack_o), 32'd1);
    istb_i = 1'b0;
    step();
    chk("t5_grant", 32'(igrant), 32'h04);
    step();
    chk("t5_irq_low", 32'(irq_o), 32'd0);
    chk("t5_grant_once", 32'(igrant), 32'd0);

    // 6. reset mid-handshake
    ireq = 8'h08;
    step();
    step();
    istb_i = 1'b1;
    step();
    step();
    chk("t6_iack_pre", 32'(iack_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_iack", 32'(iack_o), 32'd0);
    chk("t6_async_vec", 32'(ivec_o), 32'd0);
    chk("t6_async_irq", 32'(irq_o), 32'd0);
    chk("t6_async_grant", 32'(igrant), 32'd0);
    istb_i = 1'b0;
    step();
    rst = 1'b0;
    begin
      int n;
      n = 0;
      while (!irq_o && n < 2) begin
        step();
        n++;
      end
    end
    chk("t6_irq_reraise", 32'(irq_o), 32'd1);
    fetch("t6", 9'o060, 8'h08);
    ireq = 8'h00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vic_prio.md
# vic_prio

Vectored interrupt controller for one bus priority level (BR4 or BR5) on the KDF11 board. It collects level-sensitive requests from up to `NSRC` peripherals, drives the level's request line into the processor, and answers the processor's vector-fetch strobe with the vector of the highest-priority pending source. It then returns a one-cycle grant pulse to that source. One instance sits upstream of the CPU board on each of `irq_i[4]` and `irq_i[5]`; their `ivec_o`/`iack_o` are OR-merged onto the board's `ivec`/`iack_i`.

## Interface
- `NSRC`, default 8: number of request sources, 1..16; index 0 has highest priority.
- `SPUR_VEC`, default 9'o000: vector returned when a fetch finds no pending source.
- `clk_p`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset, tied to bus reset.
- `ireq`  in  NSRC  level request from each device; held until granted.
- `ivec_in`  in  NSRC*9  concatenated per-source vectors; source i occupies bits [9i+8:9i].
- `igrant`  out  NSRC  one-cycle grant pulse to the selected source.
- `irq_o`  out  1  level request to the CPU.
- `istb_i`  in  1  vector-fetch strobe from the CPU (level-gated `vstb`).
- `ivec_o`  out  9  vector; all zeros whenever `iack_o` is 0.
- `iack_o`  out  1  vector-valid acknowledge.

## Operation
- **Input register.** `ireq` is registered once into `req_q`. `irq_o = |req_q` unless the FSM is in RESOLVE or ACK, where `irq_o` is 0. This keeps the request from being re-sampled while a fetch is in progress.
- **FSM states:** IDLE, RESOLVE, ACK, RELEASE.
- **IDLE.** A cycle with `istb_i`=1 moves to RESOLVE.
- **RESOLVE.** Exactly one cycle.
  - Find the lowest index i with `req_q[i]`=1.
  - Latch `sel` = i, `hit` = 1, `vec_q` = `ivec_in[i]`.
  - If `req_q` = 0, set `hit` = 0 and `vec_q` = `SPUR_VEC`.
  - If `istb_i`=0 (aborted fetch), go to IDLE. No grant is issued.
  - Otherwise go to ACK.
- **ACK.**
  - `iack_o`=1 and `ivec_o`=`vec_q`.
  - Stay in ACK while `istb_i`=1.
  - When `istb_i`=0, go to RELEASE. If `hit`, pulse `igrant[sel]` for exactly one cycle, on the transition cycle.
- **RELEASE.** One cycle, all outputs idle, then IDLE. This is the mandatory gap that stops a still-high `ireq` from being re-granted before the device clears it.
- **Grant point.** The grant follows strobe removal rather than `iack_o` assertion, so the CPU has latched the vector before the device drops its request.
- **Mid-fetch request changes.** A source that drops `ireq` after RESOLVE still has its latched vector delivered and still receives `igrant`. The device must tolerate the extra grant.
- **Mid-fetch arrivals.** Higher-priority requests that arrive after RESOLVE wait for the next fetch.
- **Reset.** `rst` at any point, including mid-handshake, returns the FSM to IDLE and clears `req_q`, `sel`, `hit` and `vec_q`. Output reset values: `igrant`=0, `irq_o`=0, `ivec_o`=0, `iack_o`=0.

## Timing
- `ireq` to `irq_o`: 1 cycle (register stage).
- `istb_i` first sampled high at edge k:
  - RESOLVE is entered at edge k.
  - ACK is entered at edge k+1.
  - `iack_o` and `ivec_o` are valid from edge k+1, 1 cycle after the strobe, and are held stable until `istb_i` is seen low.
- `istb_i` seen low at edge m: `iack_o` drops and `igrant` pulses at edge m. RELEASE spans edge m to m+1. A new strobe is accepted at edge m+2 at the earliest.
- Back-to-back fetches are therefore ≥4 cycles apart.
- Every output is registered; there are no combinational paths from input to output.
- The CPU strobe is a four-phase handshake. The processor must hold `istb_i` until `iack_o` is seen; the block tolerates strobes of any length.

## Structure
- Shared package `vic_pkg`:
  - FSM state encoding (2-bit enum).
  - Vector width constant `VEC_W` = 9.
  - A function `prio_enc(req)` returning the lowest set index plus a found flag. The CPU board's level-select logic reuses this function.
- Single module. The priority encoder is a function, not a sub-module.
- RTL target: approximately 150–200 lines.

## Test plan
1. **Basic grant.**
   - Stimulus: reset, then `ireq[3]`=1 with vector 9'o060. Strobe 3 cycles after `irq_o` rises; hold the strobe until `iack_o`.
   - Required: `irq_o` rises 1 cycle after `ireq`. `iack_o`/`ivec_o`=060 appear 1 cycle after the strobe. `igrant[3]` pulses once when the strobe drops.
2. **Priority.**
   - Stimulus: `ireq[5]`(070) and `ireq[1]`(064) asserted together.
   - Required: the first fetch returns 064 and grants source 1. After source 1 drops, the second fetch returns 070 and grants source 5.
3. **Spurious fetch.**
   - Stimulus: strobe with `ireq`=0.
   - Required: `ivec_o`=`SPUR_VEC`, `iack_o`=1, no `igrant` bit set.
4. **Abort.**
   - Stimulus: a strobe 1 cycle wide.
   - Required: `iack_o` never rises, no grant, FSM back in IDLE. A subsequent full fetch succeeds normally.
5. **Request drop mid-fetch.**
   - Stimulus: `ireq[2]` falls during ACK.
   - Required: the vector is held unchanged and `igrant[2]` still pulses. `irq_o`=0 after RELEASE.
6. **Reset mid-handshake.**
   - Stimulus: assert `rst` while `iack_o`=1.
   - Required: all outputs are 0 immediately (asynchronous). After release, a pending `ireq` re-raises `irq_o` within 2 cycles.
